// File: rtl/cache_requester.sv
// cache_requester: queues load/store requests from the memory stage and issues
// them one at a time to the cache port. It also returns load data and runs the
// halt-time flush.
//
// Handshake semantics: a request transfers on a rising edge where
// req_valid && req_ready. req_ready depends only on registered state, so the
// pipeline may hold req_valid and its payload until that edge. On the cache
// side, enable and its payload stay stable from issue until the edge where
// done is sampled high. rsp_valid and flush_done are single-cycle pulses with
// no back-pressure.
`timescale 1ns/1ps
module cache_requester #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          req_ready,
  output logic          rsp_valid,
  output logic          rsp_wr,
  output logic [DW-1:0] rsp_rdata,
  input  logic          flush_req,
  output logic          flush_done,
  output logic          busy,
  output logic          enable,
  output logic          rd_wrt_ca,
  output logic [AW-1:0] addr_ca,
  output logic [DW-1:0] data_ca_in,
  output logic          flush,
  input  logic          idle,
  input  logic          done,
  input  logic [DW-1:0] data_ca_out,
  output logic [1:0]    state_dbg
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    FLUSH      = 2'd2,
    FLUSH_WAIT = 2'd3
  } state_t;

  state_t          state;
  logic            q_wr    [DEPTH];
  logic [AW-1:0]   q_addr  [DEPTH];
  logic [DW-1:0]   q_wdata [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic            flush_pending;
  logic            push;
  logic            pop;
  logic            q_empty;
  logic            flush_finish;

  // A pending flush blocks new requests so that the queue can drain.
  assign req_ready    = (count != CW'(DEPTH)) && !flush_pending;
  assign push         = req_valid && req_ready;
  assign pop          = (state == ISSUE) && done;
  assign q_empty      = (count == '0);
  assign flush_finish = (state == FLUSH_WAIT) && idle;
  assign busy         = !q_empty || (state != IDLE) || flush_pending;
  assign state_dbg    = state;

  // Queue storage: the payload needs no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      q_wr[tail]    <= req_wr;
      q_addr[tail]  <= req_addr;
      q_wdata[tail] <= req_wdata;
    end
  end

  // Queue pointers, occupancy count and the flush-pending flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      flush_pending <= 1'b0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Completion wins over a new request, and a repeated request while the flag is set is absorbed.
      if (flush_finish)   flush_pending <= 1'b0;
      else if (flush_req) flush_pending <= 1'b1;
    end
  end

  // Control FSM: all cache-side and response outputs are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      enable     <= 1'b0;
      flush      <= 1'b0;
      rd_wrt_ca  <= 1'b1;
      addr_ca    <= '0;
      data_ca_in <= '0;
      rsp_valid  <= 1'b0;
      rsp_wr     <= 1'b0;
      rsp_rdata  <= '0;
      flush_done <= 1'b0;
    end else begin
      rsp_valid  <= 1'b0;
      flush_done <= 1'b0;
      case (state)
        IDLE: begin
          // Queued requests have priority over a pending flush.
          if (!q_empty && idle) begin
            enable     <= 1'b1;
            rd_wrt_ca  <= !q_wr[head];
            addr_ca    <= q_addr[head];
            data_ca_in <= q_wdata[head];
            state      <= ISSUE;
          end else if (flush_pending && idle) begin
            flush <= 1'b1;
            state <= FLUSH;
          end
        end
        ISSUE: begin
          if (done) begin
            enable    <= 1'b0;
            rd_wrt_ca <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_wr    <= !rd_wrt_ca;
            rsp_rdata <= rd_wrt_ca ? data_ca_out : '0;
            state     <= IDLE;
          end
        end
        FLUSH: begin
          // Wait for the memory system to acknowledge by dropping idle.
          if (!idle) state <= FLUSH_WAIT;
        end
        FLUSH_WAIT: begin
          if (idle) begin
            flush      <= 1'b0;
            flush_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_requester.sv
// Testbench for cache_requester: directed requests against a simple memory-system
// model with a fixed 3-cycle latency, an expected-response queue and a final report.
`timescale 1ns/1ps
module tb_cache_requester;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_wr, req_ready;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_wr;
  logic [15:0] rsp_rdata;
  logic        flush_req, flush_done, busy;
  logic        enable, rd_wrt_ca, flush, idle, done;
  logic [15:0] addr_ca, data_ca_in, data_ca_out;
  logic [1:0]  state_dbg;
  logic        done_m, force_done;

  assign done = done_m | force_done;

  cache_requester #(.DEPTH(4), .AW(16), .DW(16)) dut (
    .clk(clk), .rst(rst_n),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata),
    .flush_req(flush_req), .flush_done(flush_done), .busy(busy),
    .enable(enable), .rd_wrt_ca(rd_wrt_ca), .addr_ca(addr_ca), .data_ca_in(data_ca_in),
    .flush(flush), .idle(idle), .done(done), .data_ca_out(data_ca_out),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  int sent_cnt = 0;
  int rsp_cnt = 0;
  int fd_cnt = 0;
  int flush_hi = 0;
  int overlap = 0;
  int b2b_viol = 0;
  int stab_viol = 0;
  int en_run = 0;
  int last_en_run = 0;
  int ready_bad = 0;
  int flush_rsp_at = -1;
  logic fl_win = 1'b0;
  logic stall = 1'b0;
  logic flush_prev = 1'b0;
  logic [16:0] exp_q[$];
  logic [32:0] issued_q[$];
  logic [15:0] mem [256];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory-system model ----------------
  initial begin
    int cnt;
    int ph;
    logic [16:0] first;
    cnt = 0; ph = 0; first = '0;
    done_m = 1'b0; idle = 1'b1; data_ca_out = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 6; i++) mem[i] = 16'hA000 + 16'(i);
    mem[8'h20] = 16'h1111;
    mem[8'h21] = 16'h2222;
    mem[8'h30] = 16'h3030;
    mem[8'h40] = 16'hBEEF;
    mem[8'h41] = 16'h5A5A;
    forever begin
      @(negedge clk);
      if (done_m && enable) b2b_viol++;
      done_m = 1'b0;
      if (enable && flush) overlap++;
      if (flush) begin
        flush_hi++;
        ph++;
        idle = (ph >= 3);
      end else begin
        ph = 0;
        idle = !stall;
      end
      if (enable) begin
        if (cnt == 0) first = {rd_wrt_ca, addr_ca};
        else if (first != {rd_wrt_ca, addr_ca}) stab_viol++;
        cnt++;
        if (cnt == 3) begin
          done_m = 1'b1;
          data_ca_out = mem[addr_ca[7:0]];
          if (!rd_wrt_ca) mem[addr_ca[7:0]] = data_ca_in;
          issued_q.push_back({~rd_wrt_ca, addr_ca, data_ca_in});
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // ---------------- response / event monitor ----------------
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        rsp_cnt++;
        check("rsp_expected", exp_q.size() != 0, 1);
        check("rsp_enable_low", enable, 0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_data", {rsp_wr, rsp_rdata}, e);
        end
      end
      if (flush && !flush_prev) flush_rsp_at = rsp_cnt;
      flush_prev = flush;
      if (flush_done) begin
        fd_cnt++;
        fl_win = 1'b0;
      end
      if (fl_win && req_ready) ready_bad++;
      if (enable) en_run++;
      else if (en_run != 0) begin
        last_en_run = en_run;
        en_run = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic wr, input logic [15:0] a, input logic [15:0] d, input logic fl);
    int t;
    logic acc;
    t = 0; acc = 1'b0;
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d; flush_req = fl;
    while (!acc && t < 300) begin
      acc = req_ready;
      @(negedge clk);
      flush_req = 1'b0;
      t++;
    end
    req_valid = 1'b0;
    if (acc) sent_cnt++;
    check("send_accept", acc, 1);
  endtask

  task automatic wait_rsp(input int target, input string tag);
    int t;
    t = 0;
    while (rsp_cnt < target && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check(tag, rsp_cnt, target);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    int ib;
    int fh;
    int t;
    rst_n = 1'b0; force_done = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; flush_req = 1'b0;
    cycles(3);

    // reset values
    check("rst_enable", enable, 0);
    check("rst_flush", flush, 0);
    check("rst_rd_wrt", rd_wrt_ca, 1);
    check("rst_addr", addr_ca, 0);
    check("rst_wdata", data_ca_in, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_wr", rsp_wr, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_flush_done", flush_done, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    cycles(2);

    // single load: issue one cycle after acceptance, 3 enable cycles, BEEF back
    exp_q.push_back({1'b0, 16'hBEEF});
    send(1'b0, 16'h0040, 16'h0000, 1'b0);
    check("ld_lat_before", enable, 0);
    cycles(1);
    check("ld_enable", enable, 1);
    check("ld_rd_wrt", rd_wrt_ca, 1);
    check("ld_addr", addr_ca, 16'h0040);
    check("ld_busy", busy, 1);
    wait_rsp(1, "ld_rsp_count");
    cycles(1);
    check("ld_en_cycles", last_en_run, 3);
    check("ld_idle_busy", busy, 0);

    // store then load to the same address
    ib = issued_q.size();
    exp_q.push_back({1'b1, 16'h0000});
    exp_q.push_back({1'b0, 16'h1234});
    send(1'b1, 16'h0010, 16'h1234, 1'b0);
    send(1'b0, 16'h0010, 16'h0000, 1'b0);
    wait_rsp(3, "sl_rsp_count");
    check("sl_n_issued", issued_q.size(), ib + 2);
    if (issued_q.size() >= ib + 2) begin
      check("sl_first", issued_q[ib], {1'b1, 16'h0010, 16'h1234});
      check("sl_second_wr", issued_q[ib+1][32], 0);
      check("sl_second_addr", issued_q[ib+1][31:16], 16'h0010);
    end

    // full queue with the cache stalled
    stall = 1'b1;
    cycles(2);
    ib = issued_q.size();
    base = sent_cnt;
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, 16'hA000 + 16'(i)});
    fork
      begin
        for (int i = 0; i < 6; i++) send(1'b0, 16'h0100 + 16'(i), 16'h0000, 1'b0);
      end
      begin
        cycles(8);
        check("fq_accepted4", sent_cnt - base, 4);
        check("fq_ready_low", req_ready, 0);
        check("fq_none_issued", issued_q.size(), ib);
        stall = 1'b0;
      end
    join
    wait_rsp(9, "fq_rsp_count");
    check("fq_n_issued", issued_q.size(), ib + 6);
    if (issued_q.size() >= ib + 6) begin
      for (int i = 0; i < 6; i++) check("fq_order", issued_q[ib+i][31:16], 16'h0100 + 16'(i));
    end

    // flush raised together with the second of two loads
    fh = flush_hi;
    exp_q.push_back({1'b0, 16'h1111});
    exp_q.push_back({1'b0, 16'h2222});
    send(1'b0, 16'h0020, 16'h0000, 1'b0);
    send(1'b0, 16'h0021, 16'h0000, 1'b1);
    fl_win = 1'b1;
    t = 0;
    while (fd_cnt < 1 && t < 500) begin
      cycles(1);
      t++;
    end
    check("fl_done_seen", fd_cnt, 1);
    check("fl_after_loads", flush_rsp_at, 11);
    check("fl_high_cycles", flush_hi - fh, 3);
    check("fl_ready_low", ready_bad, 0);
    cycles(6);
    check("fl_done_once", fd_cnt, 1);
    check("fl_flush_low", flush, 0);
    check("fl_ready_back", req_ready, 1);
    check("fl_busy_low", busy, 0);

    // reset in the middle of a transaction
    send(1'b0, 16'h0030, 16'h0000, 1'b0);
    t = 0;
    while (!enable && t < 50) begin
      cycles(1);
      t++;
    end
    check("rs_enable_up", enable, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rs_enable_async", enable, 0);
    check("rs_busy_async", busy, 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(8);
    check("rs_no_rsp", rsp_cnt, 11);
    exp_q.push_back({1'b0, 16'hBEEF});
    send(1'b0, 16'h0040, 16'h0000, 1'b0);
    wait_rsp(12, "rs_fresh_rsp");

    // spurious done while waiting in IDLE with one queued request
    stall = 1'b1;
    cycles(2);
    exp_q.push_back({1'b0, 16'h5A5A});
    send(1'b0, 16'h0041, 16'h0000, 1'b0);
    @(posedge clk);
    #2 force_done = 1'b1;
    @(posedge clk);
    #2 force_done = 1'b0;
    cycles(2);
    check("sp_no_rsp", rsp_cnt, 12);
    check("sp_busy", busy, 1);
    check("sp_state_idle", state_dbg, 0);
    stall = 1'b0;
    wait_rsp(13, "sp_rsp");
    cycles(10);
    check("sp_single_rsp", rsp_cnt, 13);

    // global properties
    check("no_enable_flush_overlap", overlap, 0);
    check("gap_between_txns", b2b_viol, 0);
    check("payload_stable", stab_viol, 0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_requester.md
# cache_requester

Initiator for the memory subsystem's cache-side request port. It accepts load/store requests from the pipeline memory stage into a small in-order queue and issues them one at a time over the addr_ca / data_ca_in / rd_wrt_ca / enable handshake. It returns load data to the pipeline and sequences the halt-time flush. It sits between the memory stage and memory_system, and is the only driver of that port.

## Interface

Parameters:
- DEPTH, 4 — request queue entries (power of two, ≥2)
- AW, 16 — address width
- DW, 16 — data width

Ports:
- clk  in  1  — single clock, rising edge
- rst  in  1  — asynchronous, active-low reset
- req_valid  in  1  — pipeline request present
- req_wr  in  1  — 1 = store, 0 = load
- req_addr  in  AW  — word address
- req_wdata  in  DW  — store data
- req_ready  out  1  — queue can accept this cycle
- rsp_valid  out  1  — one-cycle pulse per completed request
- rsp_wr  out  1  — completed request was a store
- rsp_rdata  out  DW  — load data; 0 for stores
- flush_req  in  1  — one-cycle pulse requesting a full cache flush
- flush_done  out  1  — one-cycle pulse when the flush completes
- busy  out  1  — queue non-empty, transaction in flight, or flush pending
- enable  out  1  — cache request strobe
- rd_wrt_ca  out  1  — 1 = read, 0 = write
- addr_ca  out  AW  — cache address
- data_ca_in  out  DW  — cache write data
- flush  out  1  — cache flush command
- idle  in  1  — memory system ready for a new command
- done  in  1  — one-cycle completion pulse
- data_ca_out  in  DW  — read data, valid in the cycle done is high

## Operation

Queue behaviour:
- Queue entries are {wr, addr, wdata}, FIFO order, with a count held in clog2(DEPTH)+1 bits.
- req_ready = (count != DEPTH) && !flush_pending.
- Enqueue on req_valid && req_ready.
- Dequeue on done in ISSUE. Enqueue and dequeue in the same cycle leave count unchanged.

FSM states: IDLE, ISSUE, FLUSH, FLUSH_WAIT.
- IDLE: if the queue is non-empty and idle=1, go to ISSUE, latching the head entry into the output registers. Otherwise, if flush_pending, the queue is empty and idle=1, go to FLUSH. Queued requests have priority over the flush.
- ISSUE:
  - Drive enable=1, rd_wrt_ca=!wr, addr_ca, data_ca_in. All four are held stable until done.
  - On done=1: capture data_ca_out (reads only), pop the queue, pulse rsp_valid next cycle, return to IDLE.
- FLUSH: flush=1. When idle=0 is observed, go to FLUSH_WAIT.
- FLUSH_WAIT: flush stays 1. When idle=1, go to IDLE, drop flush, pulse flush_done, clear flush_pending.

Flush request handling:
- flush_req sets flush_pending.
- A flush_req while already pending is ignored, so only one flush_done is produced.

Cache-side signal rules:
- Outside ISSUE, enable=0, and addr_ca and data_ca_in hold their last values.
- rd_wrt_ca=1 outside ISSUE.
- enable and flush are never high together.
- done while not in ISSUE is ignored.

## Timing

- Reset (rst=0) values:
  - enable=0, flush=0, rd_wrt_ca=1, addr_ca=0, data_ca_in=0
  - rsp_valid=0, rsp_wr=0, rsp_rdata=0, flush_done=0
  - req_ready=1, busy=0
  - Queue empty, flush_pending=0, state IDLE.
- Reset mid-transaction or mid-flush drops the transaction immediately. No rsp_valid or flush_done is produced for it.
- Issue latency: a request enqueued at edge N, into an empty queue with idle=1, has enable=1 after edge N+1.
- Completion:
  - done sampled high at edge M → enable=0 and rsp_valid=1 after edge M.
  - rsp_rdata equals data_ca_out sampled at M.
- Back-to-back: at least one cycle with enable=0 between transactions (the IDLE re-check of idle).
- Throughput: at most one transaction per (cache latency + 1) cycles.
- Full queue: req_ready falls in the cycle count reaches DEPTH. It rises in the cycle after the dequeuing done edge.
- Simultaneous req_valid and flush_req in the same cycle: the request is accepted (ready is evaluated on the prior flush_pending). The flush executes after the queue drains.
- If idle never drops after flush asserts, the block stays in FLUSH. There is no timeout.

## Test plan

- Single load:
  - Stimulus: req {wr=0, addr=0x0040}; model returns done 3 cycles after enable with data_ca_out=0xBEEF.
  - Required: enable high for 3 cycles, rd_wrt_ca=1, addr_ca=0x0040; then rsp_valid pulse with rsp_rdata=0xBEEF, rsp_wr=0.
- Store then load, same address:
  - Stimulus: store 0x1234 to 0x0010, then load 0x0010.
  - Required: first transaction has rd_wrt_ca=0, data_ca_in=0x1234; second has rd_wrt_ca=1; two rsp_valid pulses in order, rsp_wr 1 then 0, final rdata=0x1234.
- Full queue:
  - Stimulus: 6 requests on consecutive cycles with the cache stalled (idle=0).
  - Required: req_ready=0 after the 4th is accepted; requests 5 and 6 are held off until the first done; all 6 are issued in order with no duplicates.
- Flush during traffic:
  - Stimulus: 2 queued loads plus a flush_req pulse in the same cycle as the 2nd load.
  - Required: both loads complete before flush=1; flush held until idle goes low then high; exactly one flush_done; req_ready=0 throughout.
- Reset mid-transaction:
  - Stimulus: assert rst=0 while enable=1.
  - Required: enable=0, busy=0 asynchronously; no rsp_valid afterward; a fresh load after release completes normally.
- Spurious done:
  - Stimulus: done pulse while in IDLE.
  - Required: no dequeue, no rsp_valid, count unchanged.
